// File: rtl/runway_scheduler.sv
// Runway scheduler: arbitrates takeoff/landing queues onto two runways, tracks ownership.
// Optional post-release separation counters enabled by defining RUNWAY_SEPARATION_EN.
module runway_scheduler #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned SEP_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                takeoff_empty,
    input  logic [ID_WIDTH-1:0] takeoff_id,
    output logic                takeoff_pop,
    input  logic                landing_empty,
    input  logic [ID_WIDTH-1:0] landing_id,
    output logic                landing_pop,
    input  logic                emergency,
    input  logic                release_valid,
    input  logic                release_runway,
    input  logic [ID_WIDTH-1:0] release_plane_id,
    output logic                grant_valid,
    input  logic                grant_ready,
    output logic [ID_WIDTH-1:0] grant_plane_id,
    output logic                grant_runway,
    output logic                grant_landing,
    output logic [1:0]          runway_active
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_GRANT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                last_landing;
    logic                sel_landing;
    logic [ID_WIDTH-1:0] owner [2];
    logic [1:0]          free;
    logic [1:0]          rel_hit;
    logic [1:0]          set_mask;
    logic                pick_landing;
    logic                pick_takeoff;
    logic                fetch_rwy;
    logic [ID_WIDTH-1:0] fetch_id;

    if (SEP_CYCLES < 1) begin : g_sep_check
        $error("SEP_CYCLES must be at least 1");
    end

    for (genvar r = 0; r < 2; r++) begin : g_rel
        assign rel_hit[r] = release_valid && (release_runway == 1'(r)) &&
                            runway_active[r] && (owner[r] == release_plane_id);
    end

`ifdef RUNWAY_SEPARATION_EN
    localparam int unsigned SEP_W = $clog2(SEP_CYCLES + 1);

    logic [SEP_W-1:0] sep [2];

    for (genvar r = 0; r < 2; r++) begin : g_sep
        always_ff @(posedge clock) begin
            if (reset) begin
                sep[r] <= '0;
            end else if (rel_hit[r]) begin
                sep[r] <= SEP_W'(SEP_CYCLES);
            end else if (sep[r] != '0) begin
                sep[r] <= sep[r] - SEP_W'(1);
            end
        end
        assign free[r] = !runway_active[r] && (sep[r] == '0);
    end
`else
    assign free = ~runway_active;
`endif

    // Class choice; strict alternation only applies when both queues compete.
    always_comb begin
        pick_landing = 1'b0;
        pick_takeoff = 1'b0;
        if (|free) begin
            if (emergency) begin
                pick_landing = !landing_empty;
            end else if (!landing_empty && !takeoff_empty) begin
                pick_landing = !last_landing;
                pick_takeoff = last_landing;
            end else begin
                pick_landing = !landing_empty;
                pick_takeoff = !takeoff_empty;
            end
        end
    end

    always_comb begin
        state_next  = state;
        takeoff_pop = 1'b0;
        landing_pop = 1'b0;
        grant_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!reset && (pick_landing || pick_takeoff)) begin
                    takeoff_pop = pick_takeoff;
                    landing_pop = pick_landing;
                    state_next  = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_GRANT;
            ST_GRANT: begin
                grant_valid = 1'b1;
                if (grant_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign fetch_rwy = !free[0];
    assign fetch_id  = sel_landing ? landing_id : takeoff_id;
    assign set_mask  = (state == ST_FETCH) ? (fetch_rwy ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_landing   <= 1'b0;
            sel_landing    <= 1'b0;
            grant_plane_id <= '0;
            grant_runway   <= 1'b0;
            grant_landing  <= 1'b0;
            runway_active  <= '0;
            owner          <= '{default: '0};
        end else begin
            if (takeoff_pop || landing_pop) begin
                sel_landing <= landing_pop;
            end
            if (state == ST_FETCH) begin
                grant_plane_id   <= fetch_id;
                grant_runway     <= fetch_rwy;
                grant_landing    <= sel_landing;
                owner[fetch_rwy] <= fetch_id;
            end
            if (grant_valid && grant_ready) begin
                last_landing <= grant_landing;
            end
            // Released runway is never the one being locked: release needs it active.
            runway_active <= (runway_active & ~rel_hit) | set_mask;
        end
    end

endmodule
